// File: rtl/horizontal_tf_acc_if.sv
// ============================================================================
// Module      : horizontal_tf_acc_if
// Description : Bundle between the twiddle-difference generator, the
//               twiddle accumulator and the butterfly's twiddle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface horizontal_tf_acc_if #(
    parameter int S_WIDTH  = 4,
    parameter int P_WIDTH  = 64,
    parameter int SC_WIDTH = 3
) ();
    logic [S_WIDTH-1:0]  state;
    logic [SC_WIDTH-1:0] stage_counter;
    logic                CEN;
    logic [P_WIDTH-1:0]  factor_diff;
    logic [P_WIDTH-1:0]  tf_out;
    logic                tf_valid;
    logic [1:0]          tf_lane;

    modport master (
        output state, stage_counter, CEN, factor_diff,
        input  tf_out, tf_valid, tf_lane
    );

    modport slave (
        input  state, stage_counter, CEN, factor_diff,
        output tf_out, tf_valid, tf_lane
    );
endinterface

`default_nettype wire

// File: rtl/horizontal_tf_acc.sv
// ============================================================================
// Module      : horizontal_tf_acc
// Description : Four-lane Goldilocks twiddle accumulator, 3-cycle pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module horizontal_tf_acc #(
    parameter int S_WIDTH  = 4,
    parameter int P_WIDTH  = 64,
    parameter int SC_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    horizontal_tf_acc_if.slave   tf_if
);
    localparam logic [63:0] c_prime = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] c_eps   = 64'h0000_0000_FFFF_FFFF;

    logic                reinit;
    logic                in_fire;
    logic [P_WIDTH-1:0]  diff_red;

    logic [P_WIDTH-1:0]  acc_q [4];
    logic [P_WIDTH-1:0]  acc_d [4];
    logic [1:0]          ptr_q, ptr_d;

    logic                s1_vld_q, s1_vld_d;
    logic [P_WIDTH-1:0]  s1_a_q, s1_b_q;
    logic [1:0]          s1_lane_q;
    logic                s2_vld_q, s2_vld_d;
    logic [127:0]        s2_prod_q;
    logic [1:0]          s2_lane_q;
    logic                s3_vld_q, s3_vld_d;
    logic [63:0]         s3_t0_q, s3_t1_q;
    logic [1:0]          s3_lane_q;

    logic [P_WIDTH-1:0]  tf_out_q, tf_out_d;
    logic                tf_valid_q, tf_valid_d;
    logic [1:0]          tf_lane_q, tf_lane_d;

    assign reinit   = (tf_if.state == {S_WIDTH{1'b0}});
    assign in_fire  = ~tf_if.CEN
                    & (tf_if.stage_counter == {SC_WIDTH{1'b0}})
                    & (tf_if.factor_diff != '0)
                    & ~reinit;
    assign diff_red = (tf_if.factor_diff >= c_prime) ? tf_if.factor_diff - c_prime
                                                     : tf_if.factor_diff;

    logic [127:0] prod_w;
    assign prod_w = {64'd0, s1_a_q} * {64'd0, s1_b_q};

    // First half of the reduction: x_lo - a (mod p) and b*(2^32-1), registered.
    logic [63:0] x_lo;
    logic [31:0] x_a, x_b;
    logic [64:0] sub_w;
    logic [63:0] t0_w, t1_w;
    assign x_lo  = s2_prod_q[63:0];
    assign x_b   = s2_prod_q[95:64];
    assign x_a   = s2_prod_q[127:96];
    assign sub_w = {1'b0, x_lo} - {33'd0, x_a};
    assign t0_w  = sub_w[64] ? sub_w[63:0] + c_prime : sub_w[63:0];
    assign t1_w  = {x_b, 32'd0} - {32'd0, x_b};

    // Second half: add, fold the 2^64 carry back in as 2^32-1, canonicalise.
    logic [64:0] sum_w;
    logic [63:0] r_w, res_w;
    assign sum_w = {1'b0, s3_t0_q} + {1'b0, s3_t1_q};
    assign r_w   = sum_w[64] ? sum_w[63:0] + c_eps : sum_w[63:0];
    assign res_w = (r_w >= c_prime) ? r_w - c_prime : r_w;

    always_comb begin
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        s1_vld_d   = in_fire;
        s2_vld_d   = s1_vld_q;
        s3_vld_d   = s2_vld_q;
        tf_valid_d = s3_vld_q;
        tf_out_d   = tf_out_q;
        tf_lane_d  = tf_lane_q;
        if (in_fire) begin
            ptr_d = ptr_q + 2'd1;
        end
        if (s3_vld_q) begin
            tf_out_d         = res_w;
            tf_lane_d        = s3_lane_q;
            acc_d[s3_lane_q] = res_w;
        end
        // Reinit also drops a result that would land this cycle.
        if (reinit) begin
            ptr_d      = 2'd0;
            s1_vld_d   = 1'b0;
            s2_vld_d   = 1'b0;
            s3_vld_d   = 1'b0;
            tf_valid_d = 1'b0;
            tf_out_d   = tf_out_q;
            tf_lane_d  = tf_lane_q;
            for (int i = 0; i < 4; i++) begin
                acc_d[i] = 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_q      <= 2'd0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            tf_valid_q <= 1'b0;
            tf_out_q   <= '0;
            tf_lane_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= 64'd1;
            end
        end else begin
            ptr_q      <= ptr_d;
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s3_vld_q   <= s3_vld_d;
            tf_valid_q <= tf_valid_d;
            tf_out_q   <= tf_out_d;
            tf_lane_q  <= tf_lane_d;
            acc_q      <= acc_d;
        end
    end

    // Datapath registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        s1_a_q    <= acc_q[ptr_q];
        s1_b_q    <= diff_red;
        s1_lane_q <= ptr_q;
        s2_prod_q <= prod_w;
        s2_lane_q <= s1_lane_q;
        s3_t0_q   <= t0_w;
        s3_t1_q   <= t1_w;
        s3_lane_q <= s2_lane_q;
    end

    assign tf_if.tf_out   = tf_out_q;
    assign tf_if.tf_valid = tf_valid_q;
    assign tf_if.tf_lane  = tf_lane_q;

endmodule

`default_nettype wire

// File: tb/tb_horizontal_tf_acc.sv
// ============================================================================
// Module      : tb_horizontal_tf_acc
// Description : Self-checking bench for horizontal_tf_acc (vector table plus
//               scoreboard, with directed reset and random sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_horizontal_tf_acc;
    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    typedef struct {
        logic [3:0]  st;
        logic [2:0]  sc;
        logic        cen;
        logic [63:0] diff;
        logic        acc;
        logic [1:0]  lane;
        logic [63:0] out;
    } vec_t;

    typedef struct {
        int          due;
        logic [1:0]  lane;
        logic [63:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;
    logic [63:0] hold_out = '0;
    logic [1:0]  hold_lane = '0;

    vec_t vecs[$];
    exp_t sbq[$];

    logic [63:0] acc_m [4];
    logic [1:0]  ptr_m;

    horizontal_tf_acc_if bus ();

    horizontal_tf_acc dut (
        .clk   (clk),
        .rst_n (rst),
        .tf_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void add(logic [3:0] st, logic [2:0] sc, logic cen, logic [63:0] d,
                                logic a, logic [1:0] lane, logic [63:0] out);
        vec_t v;
        v.st = st; v.sc = sc; v.cen = cen; v.diff = d; v.acc = a; v.lane = lane; v.out = out;
        vecs.push_back(v);
    endfunction

    function automatic void idle(int n);
        for (int i = 0; i < n; i++) add(4'd1, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);
    endfunction

    function automatic void reinit_vec();
        add(4'd0, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);
    endfunction

    function automatic logic [63:0] mmul(logic [63:0] a, logic [63:0] b);
        logic [127:0] t;
        t = ({64'd0, a} * {64'd0, b}) % {64'd0, P};
        return t[63:0];
    endfunction

    task automatic drive(logic [3:0] st, logic [2:0] sc, logic cen, logic [63:0] d,
                         logic push, logic [1:0] lane, logic [63:0] out);
        exp_t e;
        bus.state = st;
        bus.stage_counter = sc;
        bus.CEN = cen;
        bus.factor_diff = d;
        if (push) begin
            e.due = cyc + 4; e.lane = lane; e.out = out;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Cycle-accurate monitor: valid, lane/value when expected, hold otherwise.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
                n_checks++;
                if (bus.tf_valid !== exp_v) begin
                    n_fail++;
                    $display("FAIL tf_valid @cyc %0d: got %b want %b", cyc, bus.tf_valid, exp_v);
                end
                if (exp_v) begin
                    e = sbq.pop_front();
                    n_checks++;
                    if (bus.tf_lane !== e.lane || bus.tf_out !== e.out) begin
                        n_fail++;
                        $display("FAIL result @cyc %0d: got lane %0d out %h want lane %0d out %h",
                                 cyc, bus.tf_lane, bus.tf_out, e.lane, e.out);
                    end
                    hold_out = e.out;
                    hold_lane = e.lane;
                end else begin
                    n_checks++;
                    if (bus.tf_out !== hold_out || bus.tf_lane !== hold_lane) begin
                        n_fail++;
                        $display("FAIL hold @cyc %0d: got lane %0d out %h want lane %0d out %h",
                                 cyc, bus.tf_lane, bus.tf_out, hold_lane, hold_out);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] d, dr, ex;
        logic        cen, fire;

        bus.state = 4'd1; bus.stage_counter = 3'd0; bus.CEN = 1'b0; bus.factor_diff = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.tf_out !== 64'd0 || bus.tf_valid !== 1'b0 || bus.tf_lane !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: got out %h valid %b lane %0d want 0 0 0",
                     bus.tf_out, bus.tf_valid, bus.tf_lane);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        // Burst of 2s, twice.
        for (int i = 0; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd2, 1'b1, 2'(i), 64'd2);
        idle(4);
        for (int i = 0; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd2, 1'b1, 2'(i), 64'd4);
        idle(4); reinit_vec();
        // p-1 on lane 0: (p-1)^2 = 1.
        add(4'd1, 3'd0, 1'b0, P - 64'd1, 1'b1, 2'd0, 64'hFFFF_FFFF_0000_0000);
        for (int i = 1; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd1, 1'b1, 2'(i), 64'd1);
        idle(4);
        add(4'd1, 3'd0, 1'b0, P - 64'd1, 1'b1, 2'd0, 64'd1);
        for (int i = 1; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd1, 1'b1, 2'(i), 64'd1);
        idle(4); reinit_vec();
        // 2^32 twice: 2^64 mod p = 2^32 - 1.
        add(4'd1, 3'd0, 1'b0, 64'h1_0000_0000, 1'b1, 2'd0, 64'h1_0000_0000);
        for (int i = 1; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd1, 1'b1, 2'(i), 64'd1);
        idle(4);
        add(4'd1, 3'd0, 1'b0, 64'h1_0000_0000, 1'b1, 2'd0, 64'h0000_0000_FFFF_FFFF);
        for (int i = 1; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd1, 1'b1, 2'(i), 64'd1);
        idle(4); reinit_vec();
        // diff = p reduces to 0; diff = p+5 reduces to 5.
        add(4'd1, 3'd0, 1'b0, P, 1'b1, 2'd0, 64'd0);
        for (int i = 1; i < 4; i++) add(4'd1, 3'd0, 1'b0, P + 64'd5, 1'b1, 2'(i), 64'd5);
        idle(4);
        add(4'd1, 3'd0, 1'b0, 64'd3, 1'b1, 2'd0, 64'd0);
        for (int i = 1; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd5, 1'b1, 2'(i), 64'd25);
        idle(4); reinit_vec();
        // CEN gaps mid-burst, then stage_counter != 0.
        add(4'd1, 3'd0, 1'b0, 64'd2, 1'b1, 2'd0, 64'd2);
        add(4'd1, 3'd0, 1'b1, 64'd3, 1'b0, 2'd0, 64'd0);
        add(4'd1, 3'd0, 1'b1, 64'd5, 1'b0, 2'd0, 64'd0);
        add(4'd1, 3'd0, 1'b0, 64'd7, 1'b1, 2'd1, 64'd7);
        idle(4);
        add(4'd1, 3'd0, 1'b0, 64'd11, 1'b1, 2'd2, 64'd11);
        add(4'd1, 3'd0, 1'b0, 64'd11, 1'b1, 2'd3, 64'd11);
        add(4'd1, 3'd0, 1'b0, 64'd11, 1'b1, 2'd0, 64'd22);
        add(4'd1, 3'd0, 1'b0, 64'd11, 1'b1, 2'd1, 64'd77);
        idle(4);
        for (int i = 0; i < 4; i++) add(4'd1, 3'd1, 1'b0, 64'd13, 1'b0, 2'd0, 64'd0);
        idle(2);
        add(4'd1, 3'd0, 1'b0, 64'd2, 1'b1, 2'd2, 64'd22);
        idle(4); reinit_vec();
        // Reinit one cycle into a burst drops the accepted input.
        add(4'd1, 3'd0, 1'b0, 64'd3, 1'b0, 2'd0, 64'd0);
        add(4'd0, 3'd0, 1'b0, 64'd3, 1'b0, 2'd0, 64'd0);
        add(4'd0, 3'd0, 1'b0, 64'd3, 1'b0, 2'd0, 64'd0);
        add(4'd0, 3'd0, 1'b0, 64'd3, 1'b0, 2'd0, 64'd0);
        idle(2);
        for (int i = 0; i < 4; i++) add(4'd1, 3'd0, 1'b0, 64'd3, 1'b1, 2'(i), 64'd3);
        idle(4);

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].st, vecs[i].sc, vecs[i].cen, vecs[i].diff,
                  vecs[i].acc, vecs[i].lane, vecs[i].out);

        // Reset mid-pipeline: in-flight results vanish, outputs go to 0.
        drive(4'd1, 3'd0, 1'b0, 64'd9, 1'b0, 2'd0, 64'd0);
        drive(4'd1, 3'd0, 1'b0, 64'd9, 1'b0, 2'd0, 64'd0);
        rst = 1'b1;
        drive(4'd1, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);
        hold_out = '0;
        hold_lane = '0;
        sbq.delete();
        drive(4'd1, 3'd0, 1'b0, 64'd9, 1'b0, 2'd0, 64'd0);
        drive(4'd1, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);
        rst = 1'b0;
        drive(4'd1, 3'd0, 1'b0, 64'd5, 1'b1, 2'd0, 64'd5);
        for (int i = 0; i < 6; i++) drive(4'd1, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);

        // Random full-width diffs against a % based reference model.
        drive(4'd0, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);
        for (int i = 0; i < 4; i++) acc_m[i] = 64'd1;
        ptr_m = 2'd0;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 6; i++) begin
                d = (i < 4) ? {$urandom, $urandom} : 64'd0;
                if (i < 4 && $urandom_range(0, 4) == 0) d[63:32] = 32'hFFFF_FFFF;
                cen = ($urandom_range(0, 5) == 0);
                fire = !cen && (d != 64'd0);
                dr = (d >= P) ? d - P : d;
                ex = mmul(acc_m[ptr_m], dr);
                drive(4'd1, 3'd0, cen, d, fire, ptr_m, ex);
                if (fire) begin
                    acc_m[ptr_m] = ex;
                    ptr_m = ptr_m + 2'd1;
                end
            end
        end
        for (int i = 0; i < 8; i++) drive(4'd1, 3'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0);

        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding results want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/horizontal_tf_acc.md
# horizontal_tf_acc

Twiddle-factor accumulator that sits directly downstream of the horizontal twiddle-difference generator in the R16 NTT datapath. Each nonzero 64-bit factor difference is multiplied, modulo the Goldilocks prime p = 0xFFFFFFFF00000001, into one of four running twiddle lanes. The block emits the updated twiddle to the butterfly's twiddle multiplier. The pipeline is fixed at 3 cycles. Four interleaved lanes let each lane's recurrence close without hazards.

## Interface
- S_WIDTH, 4, width of `state`
- P_WIDTH, 64, field element width (only 64 supported)
- SC_WIDTH, 3, width of `stage_counter`
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous, active-high reset (reset asserted when rst_n = 1)
- state  input  S_WIDTH  controller state; 4'd0 = IDLE, which reinitialises the lanes
- stage_counter  input  SC_WIDTH  current NTT stage; accepted only when 3'd0
- CEN  input  1  active-low enable; 1 blocks new inputs
- factor_diff  input  P_WIDTH  twiddle difference from the upstream generator; 0 means no update
- tf_out  output  P_WIDTH  updated twiddle, canonical (< p)
- tf_valid  output  1  tf_out is valid this cycle
- tf_lane  output  2  lane index of tf_out

## Operation
- Input accept: `in_fire = ~CEN & (stage_counter == 0) & (factor_diff != 0) & (state != 0)`.
- Lane pointer:
  - 2-bit; starts at 0.
  - Advances by 1 on each in_fire and wraps from 3 to 0.
  - The accepted input is assigned to the current pointer value.
- Accumulators acc[0..3]:
  - 64-bit; value after reset and after reinit is 1.
  - On in_fire to lane k: acc[k] <= acc[k] * diff' mod p, written at result time.
  - diff' = factor_diff − p if factor_diff ≥ p, otherwise factor_diff.
- Pipeline:
  - S1 registers the operands: acc[k], diff', k.
  - S2 registers the 128-bit product.
  - S3 reduces, writes acc[k], and drives tf_out, tf_lane and tf_valid = 1.
- Reduction of x = x_hi·2^64 + x_lo, with x_hi = a·2^32 + b (a, b each 32-bit):
  - r = x_lo − a + b·(2^32 − 1), computed mod p.
  - On borrow from the subtraction, add p.
  - On carry from the addition, add 2^32 − 1.
  - Apply a final conditional subtract of p so the result is < p.
- Hazard freedom:
  - A lane is revisited no sooner than 4 accepts later, and results land within 3 cycles.
  - S1 therefore always reads an up-to-date acc[k]. No forwarding is required.
- CEN = 1 only blocks new inputs. In-flight stages continue to drain.
- Reinit when state == 0:
  - acc[] = 1, lane pointer = 0.
  - All pipeline valid bits are cleared and tf_valid = 0 from the next cycle.
  - Reinit has priority over an in-flight writeback: a dropped S3 result does not update acc.
- Outputs hold their last value when tf_valid = 0, except after reset.

## Timing
- Reset: tf_out = 0, tf_valid = 0, tf_lane = 0, acc[] = 1, lane pointer = 0, all pipeline valid bits = 0. In-flight data is discarded.
- Latency: an input sampled on edge t gives tf_valid = 1 after edge t+3.
- Throughput: 1 input per cycle. The upstream burst of 4 consecutive nonzero diffs per 16 cycles maps to lanes 0, 1, 2, 3 in order.
- Simultaneous reinit and in_fire: reinit wins and the input is dropped.
- Reset asserted mid-burst:
  - Takes effect at the next edge and no tf_valid follows.
  - The first accept after release goes to lane 0 with acc = 1.
- factor_diff = 0 while CEN = 0: no accept, pointer unchanged. This is the normal gap between upstream bursts.

## Test plan
- Reset, then 4 × diff = 2 → tf_valid for 4 cycles starting at +3 with tf_out = 2, tf_lane = 0..3. Repeat the burst → tf_out = 4 on all lanes.
- Lane 0 gets diff = 0xFFFFFFFF00000000 (= p − 1); lanes 1–3 get 1; burst repeated → lane 0 outputs 0xFFFFFFFF00000000, then 0x0000000000000001.
- Lane 0 gets 0x0000000100000000 in two bursts → 0x0000000100000000, then 0x00000000FFFFFFFF (2^64 mod p).
- diff = 0xFFFFFFFF00000001 (= p) → reduced to 0, tf_out = 0. Subsequent updates on that lane → 0.
- CEN = 1 for the middle 2 inputs of a burst → only 2 outputs; the lane pointer advances by 2 only. stage_counter = 1 with valid diffs → no accept.
- state → 0 one cycle after a burst starts → no further tf_valid; the next burst restarts at lane 0 with acc = 1. Reset asserted mid-pipeline → tf_valid stays 0 and outputs are 0.
